uart_rx_core: RTL

//  Serial receive engine of the UART periph, between the uart_rx pin and the bus-side register file (sif/apb/ahb/avalon).

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx_core.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit cores.
package uart_pkg;
  localparam int UART_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_rx_st_t;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: recovers 8N1 frames (optional parity) with a programmable
// bit divider and holds one byte for the register file plus sticky error flags.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synced line
//   START | half bit wait, confirm start bit is still low
//   DATA  | sampling data bits at mid-bit, LSB first
//   PAR   | sampling the parity bit
//   STOP  | sampling the stop bit, then accept or flag the byte
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DW    = UART_DW,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] comp,
  input  logic             par_en,
  input  logic             par_odd,
  input  logic             uart_rx,
  input  logic             rx_ack,
  input  logic             err_clr,
  output logic [DW-1:0]    rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             ovf,
  output logic             frame_err,
  output logic             par_err
);
  localparam int CW = $clog2(DW);

  uart_rx_st_t      state;
  logic             rx_s;
  logic             rx_prev;
  logic [DIV_W-1:0] comp_eff;
  logic [DIV_W-1:0] full_ld;
  logic [DIV_W-1:0] half_ld;
  logic [DIV_W-1:0] timer;
  logic             tick;
  logic [CW-1:0]    bit_cnt;
  logic [DW-1:0]    shreg;
  logic             par_bad;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rx),
    .q      (rx_s)
  );

  // A divider below 2 would leave no room for a half-bit wait.
  assign comp_eff = (comp < DIV_W'(2)) ? DIV_W'(2) : comp;
  assign full_ld  = comp_eff - DIV_W'(1);
  assign half_ld  = (comp_eff >> 1) - DIV_W'(1);
  assign tick     = (timer == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rx_prev   <= 1'b1;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      if (err_clr) begin
        ovf       <= 1'b0;
        frame_err <= 1'b0;
        par_err   <= 1'b0;
      end
      // An accept in STOP below overrides this clear.
      if (rx_ack) rx_valid <= 1'b0;

      if (!rx_en) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        if (state != IDLE) timer <= tick ? full_ld : timer - DIV_W'(1);
        case (state)
          IDLE: begin
            if (rx_prev && !rx_s) begin
              state <= START;
              busy  <= 1'b1;
              timer <= half_ld;
            end
          end
          START: begin
            if (tick) begin
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          DATA: begin
            if (tick) begin
              shreg   <= {rx_s, shreg[DW-1:1]};
              bit_cnt <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(DW - 1)) begin
                par_bad <= 1'b0;
                state   <= par_en ? PAR : STOP;
              end
            end
          end
          PAR: begin
            if (tick) begin
              par_bad <= ^shreg ^ rx_s ^ par_odd;
              state   <= STOP;
            end
          end
          STOP: begin
            if (tick) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_s) begin
                frame_err <= 1'b1;
              end else if (par_bad) begin
                par_err <= 1'b1;
              end else if (!rx_valid || rx_ack) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
